// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package alu_muldiv_pkg;

    // MDCode operation encodings
    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    // Control FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

    // True for the multi-cycle arithmetic ops (MULT/MULTU/DIV/DIVU)
    function automatic logic md_is_arith(input logic [2:0] code);
        return (code[2] == 1'b0);
    endfunction

    // True for the ops that treat operands as two's complement
    function automatic logic md_is_signed(input logic [2:0] code);
        return (code == MD_MULT) || (code == MD_DIV);
    endfunction

    // True for the divide ops
    function automatic logic md_is_div(input logic [2:0] code);
        return (code == MD_DIV) || (code == MD_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_unit_md_step.sv
// One radix-2 iteration on the {acc, q} working register: shift-add for
// multiply (right shift, multiplier consumed from q[0]) and restoring
// trial-subtract for divide (left shift, quotient bits enter at q[0]).
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] diff_s;

    // Single combinational iteration of the selected datapath
    always_comb begin
        sum_s    = {1'b0, acc_i} + {1'b0, opnd_i};
        rem_sh_s = {acc_i, q_i[WIDTH-1]};
        // When the trial succeeds the difference is below 2^WIDTH, so the
        // low WIDTH bits of the subtraction are exact.
        diff_s   = rem_sh_s[WIDTH-1:0] - opnd_i;
        acc_o    = acc_i;
        q_o      = q_i;
        if (is_div) begin
            if (rem_sh_s >= {1'b0, opnd_i}) begin
                acc_o = diff_s;
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = rem_sh_s[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (q_i[0]) begin
                acc_o = sum_s[WIDTH:1];
                q_o   = {sum_s[0], q_i[WIDTH-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[WIDTH-1:1]};
                q_o   = {acc_i[0], q_i[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Operands are reduced to magnitudes on accept, iterated WIDTH times,
// then sign-corrected in a final FIX cycle that writes HI/LO.
module alu_muldiv_unit
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       MDCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, opnd_q, opnd_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d, hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
    logic             bzero_q, bzero_d, busy_q, busy_d, done_q, done_d;
    logic             dz_q, dz_d;

    logic             a_neg_s, b_neg_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s, step_acc_s, step_q_s;
    logic [WIDTH-1:0] quot_s, rem_s;
    logic [2*WIDTH-1:0] prod_s;

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .acc_i  (acc_q),
        .q_i    (q_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc_s),
        .q_o    (step_q_s)
    );

    // FSM, operand capture, iteration and sign-corrected HI/LO writeback
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        bzero_d   = bzero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;

        a_neg_s = md_is_signed(MDCode) & A[WIDTH-1];
        b_neg_s = md_is_signed(MDCode) & B[WIDTH-1];
        mag_a_s = a_neg_s ? (~A + {{(WIDTH-1){1'b0}}, 1'b1}) : A;
        mag_b_s = b_neg_s ? (~B + {{(WIDTH-1){1'b0}}, 1'b1}) : B;
        prod_s  = neg_q ? (~{acc_q, q_q} + {{(2*WIDTH-1){1'b0}}, 1'b1}) : {acc_q, q_q};
        quot_s  = neg_q ? (~q_q + {{(WIDTH-1){1'b0}}, 1'b1}) : q_q;
        rem_s   = rem_neg_q ? (~acc_q + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    busy_d = 1'b0;
                end else if (start && md_is_arith(MDCode)) begin
                    state_d   = ST_RUN;
                    busy_d    = 1'b1;
                    cnt_d     = {CNT_W{1'b0}};
                    acc_d     = {WIDTH{1'b0}};
                    is_div_d  = md_is_div(MDCode);
                    neg_d     = a_neg_s ^ b_neg_s;
                    rem_neg_d = a_neg_s;
                    bzero_d   = (B == {WIDTH{1'b0}});
                    a_raw_d   = A;
                    // Divide iterates on the dividend; multiply on the multiplier
                    q_d       = md_is_div(MDCode) ? mag_a_s : mag_b_s;
                    opnd_d    = md_is_div(MDCode) ? mag_b_s : mag_a_s;
                end else if (start && (MDCode == MD_MTHI)) begin
                    hi_d = A;
                end else if (start && (MDCode == MD_MTLO)) begin
                    lo_d = A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    acc_d   = step_acc_s;
                    q_d     = step_q_s;
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = (cnt_q == CNT_LAST) ? ST_FIX : ST_RUN;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
                if (flush) begin
                    done_d = 1'b0;
                end else if (is_div_q && bzero_q) begin
                    lo_d   = {WIDTH{1'b1}};
                    hi_d   = a_raw_q;
                    done_d = 1'b1;
                    dz_d   = 1'b1;
                end else if (is_div_q) begin
                    lo_d   = quot_s;
                    hi_d   = rem_s;
                    done_d = 1'b1;
                end else begin
                    hi_d   = prod_s[2*WIDTH-1:WIDTH];
                    lo_d   = prod_s[WIDTH-1:0];
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            opnd_q    <= {WIDTH{1'b0}};
            a_raw_q   <= {WIDTH{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            bzero_q   <= bzero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Randomised self-checking bench for alu_muldiv_unit against a plain
// 64-bit arithmetic reference model of MIPS MULT/DIV semantics.
module tb_alu_muldiv_unit;
    import alu_muldiv_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    MDCode = 3'b000;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          flush = 1'b0;
    logic          busy, done, div_zero;
    logic [W-1:0]  HI, LO;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .MDCode(MDCode),
        .A(A), .B(B), .flush(flush), .busy(busy), .done(done),
        .div_zero(div_zero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural results from plain arithmetic
    task automatic ref_op(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz);
        longint sa, sb, sr;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        rh = '0; rl = '0; rdz = 1'b0;
        case (code)
            MD_MULT:  begin sr = sa * sb; {rh, rl} = sr; end
            MD_MULTU: begin up = {32'd0, a} * {32'd0, b}; {rh, rl} = up; end
            MD_DIV: begin
                if (b == 0) begin rl = '1; rh = a; rdz = 1'b1; end
                else begin
                    sr = sa / sb; rl = sr[31:0];
                    sr = sa % sb; rh = sr[31:0];
                end
            end
            MD_DIVU: begin
                if (b == 0) begin rl = '1; rh = a; rdz = 1'b1; end
                else begin rl = a / b; rh = a % b; end
            end
            default: begin rh = hi_m; rl = lo_m; end
        endcase
    endtask

    // Issue one mul/div op, optionally pulsing a stray start at cycle inj
    task automatic run_op(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj);
        logic [W-1:0] eh, el;
        logic ed;
        int j;
        bit busy_ok, seen;
        ref_op(code, a, b, eh, el, ed);
        @(negedge clk); start = 1'b1; MDCode = code; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom;
        busy_ok = (busy === 1'b1);
        seen = 1'b0;
        j = 0;
        while (!seen && j < W + 8) begin
            if (j == inj) begin
                @(negedge clk); start = 1'b1; MDCode = 3'($urandom); A = $urandom; B = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            j++;
            if (done === 1'b1) seen = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        chk("latency", 64'(j), 64'(W + 1));
        chk("busy_run", {63'd0, busy_ok}, 64'd1);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        chk("HI", {32'd0, HI}, {32'd0, eh});
        chk("LO", {32'd0, LO}, {32'd0, el});
        chk("div_zero", {63'd0, div_zero}, {63'd0, ed});
        hi_m = eh;
        lo_m = el;
    endtask

    // Single-cycle MTHI/MTLO
    task automatic mt_op(input logic [2:0] code, input logic [W-1:0] a);
        @(negedge clk); start = 1'b1; MDCode = code; A = a;
        @(posedge clk); #1;
        start = 1'b0;
        if (code == MD_MTHI) hi_m = a; else lo_m = a;
        chk("mt_HI", {32'd0, HI}, {32'd0, hi_m});
        chk("mt_LO", {32'd0, LO}, {32'd0, lo_m});
        chk("mt_busy", {62'd0, busy, done}, 64'd0);
    endtask

    // Wait n cycles and confirm no done pulse appears
    task automatic quiet(input int n, input string tag);
        bit any;
        any = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0 && i > 0) any = 1'b1;
        end
        chk(tag, {63'd0, any}, 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_HI", {32'd0, HI}, 64'd0);
        chk("rst_LO", {32'd0, LO}, 64'd0);
        chk("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed corner operations
        run_op(MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, -1);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(MD_MULT,  32'h0000_0002, 32'h0000_0003, -1);   // issued in done cycle
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        run_op(MD_DIV,  32'hFFFF_FFF9, 32'h0000_0002, -1);
        run_op(MD_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, -1);
        run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(MD_DIVU, 32'h0000_0005, 32'h0000_0000, -1);
        @(posedge clk); #1;
        chk("dz_one_cycle", {62'd0, done, div_zero}, 64'd0);

        // MTHI/MTLO then flushed MULT
        mt_op(MD_MTHI, 32'h0000_1234);
        mt_op(MD_MTLO, 32'h0000_5678);
        @(negedge clk); start = 1'b1; MDCode = MD_MULT; A = $urandom; B = $urandom;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        quiet(40, "flush_no_done");
        chk("flush_HI", {32'd0, HI}, 64'h1234);
        chk("flush_LO", {32'd0, LO}, 64'h5678);
        run_op(MD_MULTU, pick(), pick(), -1);

        // Flush in IDLE drops start, MTHI included
        @(negedge clk); start = 1'b1; flush = 1'b1; MDCode = MD_MTHI; A = 32'hDEAD_BEEF;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        chk("idle_flush_HI", {32'd0, HI}, {32'd0, hi_m});
        @(negedge clk); start = 1'b1; flush = 1'b1; MDCode = MD_DIV; A = 32'd9; B = 32'd3;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", {63'd0, busy}, 64'd0);

        // Stray starts while busy are ignored
        run_op(MD_DIV, pick(), pick(), 12);
        run_op(MD_MULT, pick(), pick(), 3);

        // Reset in the middle of a DIV
        @(negedge clk); start = 1'b1; MDCode = MD_DIV; A = 32'd100; B = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        hi_m = '0; lo_m = '0;
        chk("midrst_HI", {32'd0, HI}, 64'd0);
        chk("midrst_LO", {32'd0, LO}, 64'd0);
        chk("midrst_busy", {62'd0, busy, done}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        quiet(40, "midrst_no_done");

        // Randomised operations, occasionally with stray starts
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0)
                mt_op(($urandom_range(0, 1) == 0) ? MD_MTHI : MD_MTLO, $urandom);
            run_op(3'($urandom_range(0, 3)), pick(), pick(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit. Companion to the single-cycle combinational ALU in the EX stage of the pipelined MIPS core.
- Executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles using a radix-2 shift-add / restoring-subtract datapath.
- Owns the architectural HI/LO registers and services MTHI/MTLO in a single cycle.
- Hazard logic stalls on busy; branch/exception logic may flush an in-flight operation.

Parameters:
- WIDTH, 32, operand and HI/LO width; even, >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- MDCode  input  3  operation select; encodings in the package.
- A  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- B  input  WIDTH  rt operand (divisor / multiplier).
- flush  input  1  abort the in-flight operation.
- busy  output  1  operation in progress; stall MFHI/MFLO/new MD ops.
- done  output  1  one-cycle pulse when HI/LO take a mul/div result.
- div_zero  output  1  one-cycle pulse with done when a DIV/DIVU had B=0.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0 at an edge): HI=0, LO=0, busy=0, done=0, div_zero=0, state IDLE, counter 0.
- Reset wins over everything, including mid-operation.
- States:
  - IDLE: start=1 with MULT/MULTU/DIV/DIVU at edge k latches operand magnitudes (absolute value for signed ops; raw for unsigned), result signs and the op, then goes to RUN. busy=1 from k+1.
  - RUN: one iteration per edge at edges k+1..k+WIDTH. At edge k+WIDTH go to FIX.
  - FIX: at edge k+WIDTH+1, apply sign correction, write HI/LO, pulse done (and div_zero if applicable), go to IDLE. busy=0 in that same cycle.
- Latency: results visible and done=1 WIDTH+1 cycles after the accepting edge (33 at default). Back-to-back start is accepted in the done cycle.
- MTHI/MTLO with start=1 in IDLE: HI or LO <= A at that edge. busy stays 0; done is not pulsed.
- Unused MDCode values are ignored. start while busy=1 is ignored, with no queuing.
- Multiply:
  - Unsigned 2*WIDTH product gives {HI,LO}.
  - Signed: product of magnitudes, two's-complement negated over 2*WIDTH bits when the operand signs differ.
- Divide:
  - Quotient goes to LO, remainder to HI.
  - Signed: quotient truncates toward zero (negated when signs differ); remainder takes the sign of the dividend.
  - MIN / -1: LO=MIN, HI=0, no flag.
  - B=0: still takes the full latency; LO=all-ones, HI=A (raw, not magnitude), div_zero=1 with done.
- flush=1 while busy: next edge returns to IDLE, busy=0, HI/LO unchanged, no done.
- flush=1 in IDLE: any start in that cycle is dropped, including MTHI/MTLO. flush beats start.
- done and div_zero are low in every cycle other than the FIX-exit cycle.

Decomposition:
- alu_muldiv_pkg holds:
  - MDCode encodings: MD_MULT=3'b000, MD_MULTU=3'b001, MD_DIV=3'b010, MD_DIVU=3'b011, MD_MTHI=3'b100, MD_MTLO=3'b101.
  - State encodings: IDLE, RUN, FIX.
- One sub-module is natural: md_step. It is the combinational single-iteration datapath: conditional add-and-shift for multiply, trial-subtract-and-shift for divide, on a {acc, q} 2*WIDTH register.
- The FSM, counter, sign handling and HI/LO live in the top.

Test Plan (WIDTH=32):
1. MULT A=FFFFFFFD, B=00000007 -> HI=FFFFFFFF, LO=FFFFFFEB; done exactly 33 cycles after the start edge, busy high for cycles 1-32.
2. MULTU A=FFFFFFFF, B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001. Back-to-back: issuing MULT 2x3 in the done cycle gives HI=0, LO=6.
3. DIV A=FFFFFFF9, B=2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU with the same operands -> LO=7FFFFFFC, HI=00000001.
4. DIV A=80000000, B=FFFFFFFF -> LO=80000000, HI=0, div_zero=0. DIVU A=5, B=0 -> LO=FFFFFFFF, HI=5, div_zero=1 with done.
5. Flush: MTHI 0x1234 then MTLO 0x5678 (one cycle each, busy stays 0); start MULT, flush at cycle 10 -> busy=0 next cycle, no done, HI/LO remain 1234/5678. A new start is then accepted.
6. Ignored inputs and reset:
   - start pulsed mid-operation is ignored; the first result is unaffected.
   - rst_n=0 at cycle 20 of a DIV clears HI/LO/busy; no done follows.
